oam_dma_controller: RTL and testbench

Bus arbiter and sequencer for NES sprite DMA. Sits between the CPU core's memory port and the system bus. It passes CPU traffic through untouched until the CPU writes a page number to $4014. It then stalls the core, takes ownership of the bus, and copies 256 bytes from page $XX00–$XXFF to the PPU OAM data port $2004 as read/write pairs, aligned to even CPU cycles.

---
 rtl/oam_dma_controller.sv | 157 +++++++++++++++
 tb/tb_oam_dma_controller.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_controller.sv
// ---------------------------------------------------------------------------
// oam_dma_controller
//
// Bus arbiter and sequencer for NES sprite DMA. Passes CPU traffic straight
// through to the system bus until the CPU writes a page number to $4014.
// It then stalls the core, takes the bus, and copies $XX00-$XXFF into the
// PPU OAM data port $2004 as read/write pairs. Every read lands on an even
// CPU cycle and every write on an odd one.
//
// Ports
//   clock         CPU clock, rising edge
//   reset_n       asynchronous active-low reset
//   cpu_addr      core address
//   cpu_mem_r_en  core access type (1 = read, 0 = write)
//   cpu_w_data    core write data
//   r_data        system bus read data (combinational, same cycle)
//   mem_addr      system bus address
//   mem_r_en      system bus access type (1 = read, 0 = write)
//   mem_w_data    system bus write data
//   cpu_rdy       0 = core must hold all state this cycle
//   dma_active    1 while the controller owns the bus
// ---------------------------------------------------------------------------
module oam_dma_controller (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_mem_r_en,
  input  logic [7:0]  cpu_w_data,
  input  logic [7:0]  r_data,
  output logic [15:0] mem_addr,
  output logic        mem_r_en,
  output logic [7:0]  mem_w_data,
  output logic        cpu_rdy,
  output logic        dma_active
);

  localparam logic [15:0] TRIG_ADDR     = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HALT  = 3'd1;
  localparam logic [2:0] ST_ALIGN = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

  logic [2:0] state_q,     state_d;
  logic [7:0] page_q,      page_d;
  logic [7:0] idx_q,       idx_d;
  logic [7:0] data_buf_q,  data_buf_d;
  logic       odd_cycle_q, odd_cycle_d;

  logic       trigger;

  // Only a write to $4014 while idle starts a transfer; during DMA the core
  // is stalled, so its bus inputs are ignored.
  assign trigger = (state_q == ST_IDLE) && !cpu_mem_r_en && (cpu_addr == TRIG_ADDR);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    page_d      = page_q;
    idx_d       = idx_q;
    data_buf_d  = data_buf_q;
    odd_cycle_d = ~odd_cycle_q;

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          page_d  = cpu_w_data;
          idx_d   = 8'h00;
          state_d = ST_HALT;
        end
      end

      // If this cycle is odd the next one is even, so the first read can
      // follow immediately; otherwise burn one alignment cycle.
      ST_HALT: begin
        state_d = odd_cycle_q ? ST_READ : ST_ALIGN;
      end

      ST_ALIGN: begin
        state_d = ST_READ;
      end

      ST_READ: begin
        data_buf_d = r_data;
        state_d    = ST_WRITE;
      end

      // idx wraps in 8 bits; the page byte is never touched, so the source
      // address cannot carry out of the page.
      ST_WRITE: begin
        idx_d   = idx_q + 8'h01;
        state_d = (idx_q == 8'hFF) ? ST_IDLE : ST_READ;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      page_q      <= 8'h00;
      idx_q       <= 8'h00;
      data_buf_q  <= 8'h00;
      odd_cycle_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      page_q      <= page_d;
      idx_q       <= idx_d;
      data_buf_q  <= data_buf_d;
      odd_cycle_q <= odd_cycle_d;
    end
  end

  // -------------------------------------------------------------------------
  // Bus outputs: pass-through in IDLE, controller-driven otherwise.
  // mem_w_data shows the buffer in every DMA state, not only WRITE.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_addr   = cpu_addr;
    mem_r_en   = cpu_mem_r_en;
    mem_w_data = cpu_w_data;
    cpu_rdy    = 1'b1;
    dma_active = 1'b0;

    if (state_q != ST_IDLE) begin
      cpu_rdy    = 1'b0;
      dma_active = 1'b1;
      mem_w_data = data_buf_q;
      case (state_q)
        ST_READ: begin
          mem_addr = {page_q, idx_q};
          mem_r_en = 1'b1;
        end
        ST_WRITE: begin
          mem_addr = OAM_DATA_ADDR;
          mem_r_en = 1'b0;
        end
        default: begin
          // HALT / ALIGN: dummy read of the page base
          mem_addr = {page_q, 8'h00};
          mem_r_en = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// ---------------------------------------------------------------------------
// Testbench for oam_dma_controller. A transaction-level model expands each
// accepted trigger into the list of bus cycles the transfer must produce and
// a per-cycle compare process checks the DUT against it. Directed literal
// checks pin stall length, read/write timing and address ranges.
// ---------------------------------------------------------------------------
module tb_oam_dma_controller;

  logic        clock;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic        cpu_mem_r_en;
  logic [7:0]  cpu_w_data;
  logic [7:0]  r_data;
  logic [15:0] mem_addr;
  logic        mem_r_en;
  logic [7:0]  mem_w_data;
  logic        cpu_rdy;
  logic        dma_active;

  logic [7:0] mem [0:65535];

  assign r_data = mem[mem_addr];

  oam_dma_controller dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cpu_addr     (cpu_addr),
    .cpu_mem_r_en (cpu_mem_r_en),
    .cpu_w_data   (cpu_w_data),
    .r_data       (r_data),
    .mem_addr     (mem_addr),
    .mem_r_en     (mem_r_en),
    .mem_w_data   (mem_w_data),
    .cpu_rdy      (cpu_rdy),
    .dma_active   (dma_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // ------------------------------------------------------------------------
  // Reference model: expected bus cycles of a pending transfer
  // ------------------------------------------------------------------------
  typedef struct packed {
    logic [15:0] a;
    logic        r;
    logic [7:0]  w;
  } bus_t;

  bus_t       exp_q[$];
  logic [7:0] m_buf;
  bit         par;
  int         cyc;

  function automatic bus_t mk(input logic [15:0] a, input logic r, input logic [7:0] w);
    bus_t e;
    e.a = a; e.r = r; e.w = w;
    return e;
  endfunction

  // par is the parity of the trigger cycle; an odd trigger needs one
  // alignment cycle so that reads fall on even cycles.
  task automatic build(input logic [7:0] pg);
    logic [7:0] prev;
    logic [7:0] d;
    logic [15:0] src;
    prev = m_buf;
    exp_q.push_back(mk({pg, 8'h00}, 1'b1, prev));
    if (par) exp_q.push_back(mk({pg, 8'h00}, 1'b1, prev));
    for (int i = 0; i < 256; i++) begin
      src = {pg, i[7:0]};
      exp_q.push_back(mk(src, 1'b1, prev));
      d = mem[src];
      exp_q.push_back(mk(16'h2004, 1'b0, d));
      prev = d;
    end
    m_buf = prev;
  endtask

  initial begin
    m_buf = 8'h00;
    par   = 1'b0;
    cyc   = 0;
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        exp_q.delete();
        m_buf = 8'h00;
        par   = 1'b0;
      end else begin
        cyc++;
        if (exp_q.size() != 0) exp_q.delete(0);
        else if (!cpu_mem_r_en && cpu_addr == 16'h4014) build(cpu_w_data);
        par = ~par;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Per-cycle compare against the model
  // ------------------------------------------------------------------------
  initial begin
    logic [15:0] ea;
    logic        er, erdy, eact;
    logic [7:0]  ew;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        ea = exp_q[0].a; er = exp_q[0].r; ew = exp_q[0].w; erdy = 1'b0; eact = 1'b1;
      end else begin
        ea = cpu_addr; er = cpu_mem_r_en; ew = cpu_w_data; erdy = 1'b1; eact = 1'b0;
      end
      checks++;
      if (mem_addr !== ea || mem_r_en !== er || mem_w_data !== ew ||
          cpu_rdy !== erdy || dma_active !== eact) begin
        errors++;
        $display("FAIL bus cyc=%0d actual a=%h r=%b w=%h rdy=%b act=%b required a=%h r=%b w=%h rdy=%b act=%b",
                 cyc, mem_addr, mem_r_en, mem_w_data, cpu_rdy, dma_active, ea, er, ew, erdy, eact);
      end
    end
  end

  // ------------------------------------------------------------------------
  // Transfer monitor (observes the DUT only)
  // ------------------------------------------------------------------------
  int          stall_cnt = 0;
  int          wr_count = 0;
  int          first_wr_cyc = 0;
  logic [15:0] last_rd = 16'h0;
  logic [15:0] first_rd = 16'h0;
  logic [7:0]  first_wr_data = 8'h0;
  logic [7:0]  last_wr_data = 8'h0;

  initial begin
    logic prev_rdy;
    prev_rdy = 1'b1;
    forever begin
      @(negedge clock);
      if (!cpu_rdy) begin
        if (prev_rdy) begin
          stall_cnt = 0;
          wr_count  = 0;
        end
        stall_cnt++;
        if (mem_r_en) last_rd = mem_addr;
        else begin
          if (wr_count == 0) begin
            first_wr_cyc  = cyc;
            first_rd      = last_rd;
            first_wr_data = mem_w_data;
          end
          last_wr_data = mem_w_data;
          wr_count++;
        end
      end
      prev_rdy = cpu_rdy;
    end
  end

  // ------------------------------------------------------------------------
  // Driver helpers
  // ------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic r, input logic [7:0] w);
    cpu_addr     = a;
    cpu_mem_r_en = r;
    cpu_w_data   = w;
  endtask

  task automatic drive_rand();
    logic [15:0] a;
    a = 16'($urandom);
    if (a == 16'h4014) a = 16'h4015;
    drive(a, 1'($urandom), 8'($urandom));
  endtask

  // Returns in the first cycle the DUT is idle, before driving that cycle.
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 1200; k++) begin
      if (!dma_active) begin
        ok = 1'b1;
        break;
      end
      drive_rand();
      next_cycle();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_idle actual=busy required=idle within 1200 cycles");
    end
  endtask

  task automatic start_dma(input logic [7:0] pg, input int want_par, output int t, output bit tp);
    wait_idle();
    if (want_par >= 0 && int'(par) != want_par) begin
      drive_rand();
      next_cycle();
    end
    drive(16'h4014, 1'b0, pg);
    t  = cyc;
    tp = par;
    next_cycle();
  endtask

  // ------------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------------
  initial begin
    int t;
    bit tp;
    bit hit;

    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    bit tp;
    bit hit;

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

    drive(16'h0000, 1'b1, 8'h00);
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #3 reset_n = 1'b1;
    next_cycle();

    // reset state
    check("rst_rdy", 32'(cpu_rdy), 32'd1);
    check("rst_active", 32'(dma_active), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'(cpu_addr));

    for (int k = 0; k < 8; k++) begin
      drive_rand();
      next_cycle();
    end

    // non-triggers
    drive(16'h4014, 1'b1, 8'h02); next_cycle();
    check("nt_read4014", 32'(dma_active), 32'd0);
    drive(16'h4015, 1'b0, 8'h02); next_cycle();
    check("nt_write4015", 32'(dma_active), 32'd0);
    drive(16'h2004, 1'b0, 8'h02); next_cycle();
    check("nt_write2004", 32'(dma_active), 32'd0);

    // even trigger, page $02
    start_dma(8'h02, 0, t, tp);
    wait_idle();
    check("even_stall", 32'(stall_cnt), 32'd513);
    check("even_first_wr", 32'(first_wr_cyc - t), 32'd3);
    check("even_wr_cnt", 32'(wr_count), 32'd256);
    check("even_first_rd", 32'(first_rd), 32'h0200);
    check("even_first_data", 32'(first_wr_data), 32'h5A);
    check("even_last_data", 32'(last_wr_data), 32'hA5);

    // odd trigger, page $02
    start_dma(8'h02, 1, t, tp);
    wait_idle();
    check("odd_stall", 32'(stall_cnt), 32'd514);
    check("odd_first_wr", 32'(first_wr_cyc - t), 32'd4);
    check("odd_first_rd", 32'(first_rd), 32'h0200);
    check("odd_wr_cnt", 32'(wr_count), 32'd256);

    // page $FF: no carry into $0000
    start_dma(8'hFF, -1, t, tp);
    wait_idle();
    check("pgff_first_rd", 32'(first_rd), 32'hFF00);
    check("pgff_last_rd", 32'(last_rd), 32'hFFFF);
    check("pgff_wr_cnt", 32'(wr_count), 32'd256);
    check("pgff_stall", 32'(stall_cnt), tp ? 32'd514 : 32'd513);

    // back-to-back: trigger in the first idle cycle
    start_dma(8'h04, -1, t, tp);
    wait_idle();
    check("b2b_first_rd", 32'(first_rd), 32'h0400);
    check("b2b_wr_cnt", 32'(wr_count), 32'd256);
    check("b2b_stall", 32'(stall_cnt), tp ? 32'd514 : 32'd513);
    check("b2b_first_wr", 32'(first_wr_cyc - t), tp ? 32'd4 : 32'd3);
    check("b2b_last_data", 32'(last_wr_data), 32'(mem[16'h04FF]));

    // reset mid-transfer after the write of idx $40
    start_dma(8'h05, -1, t, tp);
    hit = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (wr_count == 65) begin
        hit = 1'b1;
        break;
      end
      drive_rand();
      next_cycle();
    end
    check("mid_reached_idx40", 32'(hit), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rdy", 32'(cpu_rdy), 32'd1);
    check("mid_active", 32'(dma_active), 32'd0);
    check("mid_addr", 32'(mem_addr), 32'(cpu_addr));
    check("mid_ren", 32'(mem_r_en), 32'(cpu_mem_r_en));
    check("mid_wdata", 32'(mem_w_data), 32'(cpu_w_data));
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    next_cycle();

    start_dma(8'h03, -1, t, tp);
    wait_idle();
    check("restart_first_rd", 32'(first_rd), 32'h0300);
    check("restart_wr_cnt", 32'(wr_count), 32'd256);
    check("restart_stall", 32'(stall_cnt), tp ? 32'd514 : 32'd513);

    for (int k = 0; k < 4; k++) begin
      drive_rand();
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
